// File: rtl/seg_scan_pkg.sv
// Shared types and constants for the multiplexed 7-segment display path.
package seg_scan_pkg;

    // One digit buffer entry: blank forces the digit dark, dp lights the decimal point.
    typedef struct packed {
        logic       blank;
        logic       dp;
        logic [3:0] hex;
    } digit_entry_t;

    // All segments / all selects off (active-low lines).
    localparam logic [7:0] SEG_OFF = 8'hFF;

    localparam digit_entry_t ENTRY_BLANK = '{blank: 1'b1, dp: 1'b0, hex: 4'h0};

    // Active-low {g,f,e,d,c,b,a} patterns, indexed by hex value 0..F.
    localparam logic [15:0][6:0] HEX_SEG_N = {
        7'h0E, 7'h06, 7'h21, 7'h46,   // F E d C
        7'h03, 7'h08, 7'h10, 7'h00,   // b A 9 8
        7'h78, 7'h02, 7'h12, 7'h19,   // 7 6 5 4
        7'h30, 7'h24, 7'h79, 7'h40    // 3 2 1 0
    };

endpackage

// File: rtl/seg_scan_driver_hex_to_seg.sv
// Combinational digit entry to active-low {dp,g,f,e,d,c,b,a} decode.
module hex_to_seg
    import seg_scan_pkg::*;
(
    input  digit_entry_t i_entry,
    output logic [7:0]   o_seg
);

    // Blank entries stay dark; otherwise dp drives bit 7 low and the hex table fills the rest.
    always_comb begin
        o_seg = SEG_OFF;
        if (!i_entry.blank) begin
            o_seg = {~i_entry.dp, HEX_SEG_N[i_entry.hex]};
        end
    end

endmodule

// File: rtl/seg_scan_driver.sv
// Eight-digit multiplexed 7-segment scan driver with guard interval and PWM brightness.
module seg_scan_driver
    import seg_scan_pkg::*;
#(
    parameter int F_CLK  = 50000000,
    parameter int F_SCAN = 1000,
    parameter int GUARD  = 2500
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_wr_en,
    input  logic [2:0] i_wr_addr,
    input  logic [5:0] i_wr_data,
    input  logic [2:0] i_bright,
    output logic [7:0] o_cs,
    output logic [7:0] o_dig_sel,
    output logic       o_frame
);

    localparam int DIV   = F_CLK / F_SCAN;
    localparam int CNT_W = $clog2(DIV);
    localparam int UNIT  = (DIV - GUARD) / 8;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV - 1);
    localparam logic [CNT_W-1:0] GUARD_C  = CNT_W'(GUARD);
    localparam logic [CNT_W+2:0] UNIT_X   = (CNT_W + 3)'(UNIT);

    if (DIV - GUARD < 8) begin : g_bad_cfg
        $error("seg_scan_driver: DIV-GUARD must be at least 8");
    end

    logic [CNT_W-1:0] slot_cnt_q, slot_cnt_d;
    logic [2:0]       ptr_q, ptr_d;
    digit_entry_t     buf_q [8];
    digit_entry_t     buf_d [8];
    digit_entry_t     slot_entry_q, slot_entry_d;
    logic [2:0]       slot_bright_q, slot_bright_d;
    logic [7:0]       cs_q, cs_d;
    logic [7:0]       seg_q, seg_d;
    logic             frame_q, frame_d;

    digit_entry_t     cur_entry;
    logic [2:0]       cur_bright;
    logic [CNT_W-1:0] cnt_off;
    logic [CNT_W+2:0] win_len;
    logic             slot_last;
    logic             win_on;
    logic [7:0]       dec_seg;

    // At slot_cnt==0 the slot registers are being loaded, so the window logic
    // looks straight at the buffer and i_bright for that one cycle.
    always_comb begin
        if (slot_cnt_q == '0) begin
            cur_entry  = buf_q[ptr_q];
            cur_bright = i_bright;
        end else begin
            cur_entry  = slot_entry_q;
            cur_bright = slot_bright_q;
        end
    end

    hex_to_seg u_hex_to_seg (
        .i_entry (cur_entry),
        .o_seg   (dec_seg)
    );

    // Next-state for counter, pointer, buffer, slot latch and registered outputs.
    always_comb begin
        slot_last = (slot_cnt_q == CNT_LAST);
        cnt_off   = slot_cnt_q - GUARD_C;
        win_len   = UNIT_X * ((CNT_W + 3)'(cur_bright) + (CNT_W + 3)'(1));
        win_on    = (slot_cnt_q >= GUARD_C) && ({3'b000, cnt_off} < win_len);

        slot_cnt_d = slot_last ? '0 : slot_cnt_q + CNT_W'(1);
        ptr_d      = slot_last ? ptr_q + 3'd1 : ptr_q;

        buf_d = buf_q;
        if (i_wr_en) begin
            buf_d[i_wr_addr] = digit_entry_t'(i_wr_data);
        end

        slot_entry_d  = cur_entry;
        slot_bright_d = cur_bright;

        cs_d    = win_on ? ~(8'd1 << ptr_q) : SEG_OFF;
        seg_d   = win_on ? dec_seg : SEG_OFF;
        frame_d = slot_last && (ptr_q == 3'd7);
    end

    // State and output registers; reset clears the buffer to blank entries.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            slot_cnt_q    <= '0;
            ptr_q         <= '0;
            for (int i = 0; i < 8; i++) begin
                buf_q[i] <= ENTRY_BLANK;
            end
            slot_entry_q  <= ENTRY_BLANK;
            slot_bright_q <= '0;
            cs_q          <= SEG_OFF;
            seg_q         <= SEG_OFF;
            frame_q       <= 1'b0;
        end else begin
            slot_cnt_q    <= slot_cnt_d;
            ptr_q         <= ptr_d;
            for (int i = 0; i < 8; i++) begin
                buf_q[i] <= buf_d[i];
            end
            slot_entry_q  <= slot_entry_d;
            slot_bright_q <= slot_bright_d;
            cs_q          <= cs_d;
            seg_q         <= seg_d;
            frame_q       <= frame_d;
        end
    end

    assign o_cs      = cs_q;
    assign o_dig_sel = seg_q;
    assign o_frame   = frame_q;

endmodule

// File: tb/tb_seg_scan_driver.sv
// Directed bench for seg_scan_driver at DIV=32, GUARD=8, UNIT=3.
module tb_seg_scan_driver;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       wr_en = 1'b0;
    logic [2:0] wr_addr = '0;
    logic [5:0] wr_data = '0;
    logic [2:0] bright = '0;
    logic [7:0] cs;
    logic [7:0] seg;
    logic       frame;

    int tests_run = 0;
    int fails = 0;
    int edges;

    seg_scan_driver #(.F_CLK(3200), .F_SCAN(100), .GUARD(8)) dut (
        .i_clk     (clk),
        .i_rst_n   (rst_n),
        .i_wr_en   (wr_en),
        .i_wr_addr (wr_addr),
        .i_wr_data (wr_data),
        .i_bright  (bright),
        .o_cs      (cs),
        .o_dig_sel (seg),
        .o_frame   (frame)
    );

    always #5 clk = ~clk;

    // Edges since reset release; after edge k the outputs reflect slot-counter cycle k-1.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) edges <= 0;
        else        edges <= edges + 1;
    end

    task automatic do_reset(input logic [2:0] b);
        rst_n = 1'b0;
        wr_en = 1'b0;
        bright = b;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic wr(input logic [2:0] a, input logic [5:0] d);
        wr_addr = a;
        wr_data = d;
        wr_en   = 1'b1;
        @(negedge clk);
        wr_en   = 1'b0;
    endtask

    task automatic wait_edges(input int target);
        int guard_cnt = 0;
        while (edges < target) begin
            @(negedge clk);
            guard_cnt++;
            if (guard_cnt > 5000) begin
                $display("FAIL wait_timeout: edges=%0d required=%0d", edges, target);
                $fatal(1, "timeout");
            end
        end
    endtask

    // Samples one full slot (absolute slot index) and summarises the lit window.
    task automatic measure_slot(input int slot_abs, input logic [7:0] exp_cs,
                                input logic [7:0] exp_seg, input int chg_at,
                                input logic [2:0] chg_val, input int wr_at,
                                input logic [2:0] wa, input logic [5:0] wd,
                                output int on_cnt, output int first_on, output int bad);
        int base = slot_abs * 32;
        on_cnt = 0;
        first_on = -1;
        bad = 0;
        for (int off = 0; off < 32; off++) begin
            wait_edges(base + off + 1);
            if (cs !== 8'hFF) begin
                on_cnt++;
                if (first_on < 0) first_on = off;
                if (cs !== exp_cs || seg !== exp_seg) bad++;
            end else if (seg !== 8'hFF) begin
                bad++;
            end
            wr_en = 1'b0;
            if (off == chg_at) bright = chg_val;
            if (off == wr_at) begin
                wr_addr = wa;
                wr_data = wd;
                wr_en   = 1'b1;
            end
        end
        wr_en = 1'b0;
    endtask

    task automatic test_reset;
        int dark_bad = 0;
        do_reset(3'd7);
        wr(3'd0, 6'b00_0101);
        wait_edges(268);
        tests_run++;
        if (cs !== 8'hFE || seg !== 8'h92) begin
            fails++;
            $display("FAIL reset_pre_lit: cs=%h seg=%h required cs=fe seg=92", cs, seg);
        end
        #2 rst_n = 1'b0;
        #1;
        tests_run++;
        if (cs !== 8'hFF) begin
            fails++;
            $display("FAIL reset_cs: got %h required ff", cs);
        end
        tests_run++;
        if (seg !== 8'hFF) begin
            fails++;
            $display("FAIL reset_seg: got %h required ff", seg);
        end
        tests_run++;
        if (frame !== 1'b0) begin
            fails++;
            $display("FAIL reset_frame: got %b required 0", frame);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 256; k++) begin
            @(negedge clk);
            if (seg !== 8'hFF) dark_bad++;
        end
        tests_run++;
        if (dark_bad != 0) begin
            fails++;
            $display("FAIL reset_dark_frame: %0d lit cycles, required 0", dark_bad);
        end
    endtask

    task automatic test_digit3;
        int n, f, b;
        do_reset(3'd7);
        wr(3'd3, 6'b01_0101);
        measure_slot(2, 8'hFB, 8'hFF, -1, 3'd0, -1, 3'd0, 6'd0, n, f, b);
        tests_run++;
        if (n != 24 || b != 0) begin
            fails++;
            $display("FAIL blank_slot2: on=%0d bad=%0d required on=24 bad=0", n, b);
        end
        measure_slot(3, 8'hF7, 8'h12, -1, 3'd0, -1, 3'd0, 6'd0, n, f, b);
        tests_run++;
        if (n != 24) begin
            fails++;
            $display("FAIL digit3_width: got %0d required 24", n);
        end
        tests_run++;
        if (f != 8) begin
            fails++;
            $display("FAIL digit3_guard: first on at %0d required 8", f);
        end
        tests_run++;
        if (b != 0) begin
            fails++;
            $display("FAIL digit3_value: %0d wrong cycles required 0", b);
        end
    endtask

    task automatic test_brightness;
        int n, f, b;
        do_reset(3'd0);
        wr(3'd1, 6'b00_0001);
        wr(3'd2, 6'b00_0010);
        wr(3'd3, 6'b00_0011);
        measure_slot(1, 8'hFD, 8'hF9, 9, 3'd4, -1, 3'd0, 6'd0, n, f, b);
        tests_run++;
        if (n != 3 || f != 8 || b != 0) begin
            fails++;
            $display("FAIL bright0_window: on=%0d first=%0d bad=%0d required 3 8 0", n, f, b);
        end
        measure_slot(2, 8'hFB, 8'hA4, -1, 3'd0, -1, 3'd0, 6'd0, n, f, b);
        tests_run++;
        if (n != 15 || f != 8 || b != 0) begin
            fails++;
            $display("FAIL bright4_window: on=%0d first=%0d bad=%0d required 15 8 0", n, f, b);
        end
        measure_slot(3, 8'hF7, 8'hB0, -1, 3'd0, -1, 3'd0, 6'd0, n, f, b);
        tests_run++;
        if (n != 15 || b != 0) begin
            fails++;
            $display("FAIL bright4_slot3: on=%0d bad=%0d required 15 0", n, b);
        end
    endtask

    task automatic test_mid_write;
        int n, f, b;
        do_reset(3'd7);
        wr(3'd2, 6'b00_0011);
        measure_slot(2, 8'hFB, 8'hB0, -1, 3'd0, 4, 3'd2, 6'b01_1010, n, f, b);
        tests_run++;
        if (n != 24 || b != 0) begin
            fails++;
            $display("FAIL midwrite_current: on=%0d bad=%0d required 24 0", n, b);
        end
        measure_slot(10, 8'hFB, 8'h08, -1, 3'd0, -1, 3'd0, 6'd0, n, f, b);
        tests_run++;
        if (n != 24 || b != 0) begin
            fails++;
            $display("FAIL midwrite_next: on=%0d bad=%0d required 24 0", n, b);
        end
    endtask

    task automatic test_blank;
        int n, f, b;
        do_reset(3'd7);
        wr(3'd6, 6'b10_1000);
        measure_slot(6, 8'hBF, 8'hFF, -1, 3'd0, -1, 3'd0, 6'd0, n, f, b);
        tests_run++;
        if (n != 24 || f != 8 || b != 0) begin
            fails++;
            $display("FAIL blank_digit6: on=%0d first=%0d bad=%0d required 24 8 0", n, f, b);
        end
    endtask

    task automatic test_frame;
        int pulses = 0;
        int p1 = -1;
        int p2 = -1;
        do_reset(3'd7);
        for (int k = 1; k <= 600; k++) begin
            @(negedge clk);
            if (frame === 1'b1) begin
                pulses++;
                if (p1 < 0) p1 = edges;
                else if (p2 < 0) p2 = edges;
            end
        end
        tests_run++;
        if (pulses != 2) begin
            fails++;
            $display("FAIL frame_count: got %0d required 2", pulses);
        end
        tests_run++;
        if (p1 != 256 || p2 != 512) begin
            fails++;
            $display("FAIL frame_align: got %0d,%0d required 256,512", p1, p2);
        end
    endtask

    task automatic test_back_to_back;
        int n, f, b;
        do_reset(3'd7);
        wr(3'd0, 6'b00_0001);
        wr(3'd0, 6'b00_0010);
        measure_slot(8, 8'hFE, 8'hA4, -1, 3'd0, -1, 3'd0, 6'd0, n, f, b);
        tests_run++;
        if (n != 24 || b != 0) begin
            fails++;
            $display("FAIL back_to_back: on=%0d bad=%0d required 24 0", n, b);
        end
    endtask

    initial begin
        test_reset;
        test_digit3;
        test_brightness;
        test_mid_write;
        test_blank;
        test_frame;
        test_back_to_back;
        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end

endmodule

// File: doc/seg_scan_driver.md
# seg_scan_driver

Multiplexed 8-digit 7-segment display driver, the output-side counterpart to the key-scanning input path. It holds a write-addressable 8-entry digit buffer and scans one digit per slot onto shared active-low chip-select and segment lines. Each slot has a ghosting guard interval and PWM brightness control. It sits between control logic (a key handler, counters, etc.) and the board display pins.

## Interface
- F_CLK, 50000000: input clock frequency in Hz.
- F_SCAN, 1000: digit slot rate in Hz. DIV = F_CLK/F_SCAN cycles per slot.
- GUARD, 2500: blank cycles at the start of each slot. Elaboration error unless DIV-GUARD >= 8.

- i_clk  in  1  system clock.
- i_rst_n  in  1  reset i_rst_n, asynchronous, active-low.
- i_wr_en  in  1  write strobe, one cycle per write.
- i_wr_addr  in  3  digit index 0..7. Digit 0 maps to o_cs[0].
- i_wr_data  in  6  digit entry {blank, dp, hex[3:0]}.
- i_bright  in  3  brightness level 0..7. 7 is brightest.
- o_cs  out  8  digit select, active-low one-hot. All-ones means no digit on.
- o_dig_sel  out  8  segments {dp,g,f,e,d,c,b,a}, active-low.
- o_frame  out  1  one-cycle pulse when the pointer wraps from 7 to 0.

## Operation
- Slot counter: counts 0..DIV-1 and wraps. At the wrap, the digit pointer advances 0→1→…→7→0.
- Slot latch: at slot_cnt==0, the driver copies the buffer entry at the new pointer and i_bright into slot registers. A write or brightness change in mid-slot never changes the current slot.
- Lighting window: ON when slot_cnt >= GUARD and (slot_cnt-GUARD) < UNIT*(bright+1), with UNIT = (DIV-GUARD)>>3. The window width is bright+1 units.
  - When ON: o_cs = ~(1<<ptr) and o_dig_sel = decoded latched entry.
  - When OFF: o_cs = 8'hFF and o_dig_sel = 8'hFF.
- Blank entry: an entry with blank=1 forces o_dig_sel = 8'hFF. o_cs still asserts in the window, so the digit is selected but dark.
- Decode: active-low patterns for hex 0..F. dp=1 drives bit7 low.
- Writes:
  - i_wr_en writes buffer[i_wr_addr] on the clock edge. Every write is accepted; there is no backpressure.
  - A write to the currently displayed digit takes effect the next time the pointer reaches that digit.
  - Two writes to one address in consecutive cycles: last write wins.
- Width rules:
  - slot_cnt width is $clog2(DIV).
  - UNIT*(bright+1) is computed at slot_cnt width + 3 bits with no overflow.
  - The pointer wraps modulo 8.

## Timing
- Reset values:
  - o_cs = 8'hFF, o_dig_sel = 8'hFF, o_frame = 0.
  - Pointer = 0, slot_cnt = 0, slot registers blank.
  - All buffer entries = 6'b10_0000 (blank).
- Outputs are registered. o_cs and o_dig_sel change one cycle after the slot_cnt value that defines them.
- First ON cycle after reset: digit 0 lights at cycle GUARD+1 after reset release, if its entry has been written before slot start. Otherwise digit 0 stays dark for that slot.
- o_frame asserts in the cycle after the 7→0 pointer advance. Its period is 8*DIV cycles.
- Reset asserted mid-slot: all outputs return to their reset values asynchronously, and the buffer is cleared.
- An i_bright change mid-slot applies from the next slot.

## Structure
- seg_scan_pkg holds:
  - the digit_entry_t packed struct {blank, dp, hex}.
  - the SEG_OFF = 8'hFF constant.
  - the 16-entry active-low hex pattern constant.
- Sub-module hex_to_seg: combinational entry→pattern decode, reusable by other display blocks.
- The top level holds the slot counter, pointer, buffer, slot latch and window compare.

## Test plan
All scenarios use F_CLK=3200, F_SCAN=100, GUARD=8, giving DIV=32 and UNIT=3.
- Reset: assert i_rst_n=0 mid-slot → o_cs=8'hFF, o_dig_sel=8'hFF, o_frame=0 immediately. After release, all digits stay dark for a full 256-cycle frame.
- Write digit 3 = {0,1,4'h5} and bright=7 → in slot 3, o_cs=8'hF7 and o_dig_sel=8'h12 for 24 cycles after 8 guard cycles.
- Brightness: bright=0 → each ON window lasts exactly 3 cycles. Changing to bright=4 mid-slot gives 15-cycle windows only from the next slot.
- Write to the displayed digit mid-slot: digit 2 = 'A' while slot 2 is active → current slot keeps the old pattern. The next visit shows 8'h08.
- Blank entry {1,0,4'h8} at digit 6 → o_cs=8'hBF during the window while o_dig_sel stays 8'hFF.
- Frame: o_frame pulses once every 256 cycles, one cycle wide, aligned to the 7→0 advance. Back-to-back writes to addr 0 (values 1 then 2) display 2.
